de2_115_qsys_key_pio_in: RTL and testbench



---
 rtl/de2_115_qsys_key_pio_in.sv | 127 ++++++++++++
 tb/tb_de2_115_qsys_key_pio_in.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_qsys_key_pio_in.sv
// rtl/de2_115_qsys_key_pio_in.sv - Avalon-MM input PIO with debounce, edge capture and irq
//
// Samples the KEY pushbuttons through a two-flop synchronizer, and debounces each bit
// independently. Selected edges of the debounced value are latched in edge_capture, and
// a maskable level interrupt is raised.
//
// Ports:
//   clk, reset_n   system clock, asynchronous active-low reset
//   address        word select: 0 data, 1 irq_mask, 2 reserved, 3 edge_capture (W1C)
//   chipselect     slave select; a write is chipselect && !write_n
//   write_n        active-low write strobe
//   writedata      write data; bits above WIDTH-1 are ignored
//   in_port        raw asynchronous pin inputs
//   readdata       registered read data, one cycle after address
//   irq            |(edge_capture & irq_mask)
module de2_115_qsys_key_pio_in #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit for the
  // DEBOUNCE_CYCLES == 1 case.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;

  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic             wr;
  logic [31:0]      rd_mux;

  assign wr = chipselect && !write_n;

  // A bit is accepted on the edge its counter has already reached CNT_MAX while the
  // synchronized input still differs; that same edge decides whether it is a capture.
  always_comb begin
    accept   = '0;
    edge_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      case (EDGE_TYPE)
        0:       edge_set[i] = accept[i] && sync2[i];
        1:       edge_set[i] = accept[i] && !sync2[i];
        default: edge_set[i] = accept[i];
      endcase
    end
  end

  assign edge_clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= {WIDTH{IDLE_LEVEL}};
      sync2  <= {WIDTH{IDLE_LEVEL}};
      stable <= {WIDTH{IDLE_LEVEL}};
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Set has priority over a same-cycle write-1-to-clear so no edge is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq_mask     <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
      if (wr && address == 2'd1) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_de2_115_qsys_key_pio_in.sv
// tb/tb_de2_115_qsys_key_pio_in.sv - scoreboard bench for the KEY input PIO
//
// Three instances share bus and pins: falling-edge (main), any-edge and rising-edge
// builds, all with DEBOUNCE_CYCLES=4. Reads push expectations; a monitor checks the
// registered readdata/irq one cycle later.
module tb_de2_115_qsys_key_pio_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd_m, rd_a, rd_r;
  logic        irq_m, irq_a, irq_r;

  always #5 clk = ~clk;

  de2_115_qsys_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_m), .irq(irq_m));

  de2_115_qsys_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_a), .irq(irq_a));

  de2_115_qsys_key_pio_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .IDLE_LEVEL(1'b1)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd_r), .irq(irq_r));

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } sb_t;

  sb_t  sb[$];
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      passed++;
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        logic [31:0] act;
        e = sb.pop_front();
        case (e.sel)
          0:       act = rd_m;
          1:       act = rd_a;
          2:       act = rd_r;
          3:       act = {31'd0, irq_m};
          4:       act = {31'd0, irq_a};
          default: act = {31'd0, irq_r};
        endcase
        check(e.name, act, e.exp);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] exp, input string nm);
    sb_t e;
    e.sel = sel;
    e.exp = exp;
    e.name = nm;
    sb.push_back(e);
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic rd(input int sel, input logic [1:0] a, input logic [31:0] exp, input string nm);
    address = a;
    expect_out(sel, exp, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n    = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;

    // Reset asserted mid-cycle, then released between edges.
    #3 reset_n = 1'b0;
    #1;
    check("rst_readdata", rd_m, 32'd0);
    check("rst_irq_async", {31'd0, irq_m}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(0, 2'd0, 32'h0000_000F, "rst_data");
    rd(0, 2'd1, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_cap");
    expect_out(3, 32'd0, "rst_irq");

    // Bit1 low for 3 cycles only: counter peaks at 3 and clears without accepting.
    in_port = 4'hD;
    idle(3);
    in_port = 4'hF;
    idle(8);
    rd(0, 2'd0, 32'h0000_000F, "glitch_data");
    rd(0, 2'd3, 32'h0, "glitch_cap");

    // Press bit0; stable updates on edge 6, so readdata shows it on read 7.
    in_port = 4'hE;
    for (int k = 0; k < 6; k++) rd(0, 2'd0, 32'h0000_000F, "press_latency_pre");
    rd(0, 2'd0, 32'h0000_000E, "press_latency_hit");
    rd(0, 2'd3, 32'h1, "press_cap_fall");
    rd(1, 2'd3, 32'h1, "press_cap_any");
    rd(2, 2'd3, 32'h0, "press_cap_rise");
    expect_out(3, 32'd0, "press_irq_masked");

    // Mask bit0 (upper writedata bits ignored), then clear via W1C.
    wr(2'd1, 32'hFFFF_FFF1);
    rd(0, 2'd1, 32'h1, "mask_readback");
    expect_out(3, 32'd1, "irq_set_fall");
    expect_out(4, 32'd1, "irq_set_any");
    expect_out(5, 32'd0, "irq_rise_none");
    wr(2'd0, 32'h0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd0, 32'h0000_000E, "data_read_only");
    rd(0, 2'd2, 32'h0, "reserved_zero");
    wr(2'd3, 32'h1);
    expect_out(3, 32'd0, "irq_cleared");
    rd(0, 2'd3, 32'h0, "cap_cleared");
    rd(1, 2'd3, 32'h0, "cap_cleared_any");

    // Bit2 press accepted on edge 6; W1C of bit2 lands on that same edge.
    in_port = 4'hA;
    idle(5);
    wr(2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, "collide_set_wins");
    rd(1, 2'd3, 32'h4, "collide_set_wins_any");
    rd(2, 2'd3, 32'h0, "collide_rise_none");
    rd(0, 2'd0, 32'h0000_000A, "collide_data");
    expect_out(3, 32'd0, "collide_irq_unmasked_bit");

    // Bit3 press then release with capture cleared in between.
    wr(2'd3, 32'hF);
    in_port = 4'h2;
    idle(8);
    rd(0, 2'd3, 32'h8, "bit3_press_fall");
    rd(1, 2'd3, 32'h8, "bit3_press_any");
    rd(2, 2'd3, 32'h0, "bit3_press_rise");
    wr(2'd3, 32'hF);
    in_port = 4'hA;
    idle(8);
    rd(0, 2'd3, 32'h0, "bit3_release_fall");
    rd(1, 2'd3, 32'h8, "bit3_release_any");
    rd(2, 2'd3, 32'h8, "bit3_release_rise");
    rd(0, 2'd0, 32'h0000_000A, "bit3_release_data");

    // Reset during an in-progress bit2 release: no capture, state back to idle.
    in_port = 4'hE;
    idle(3);
    #2 reset_n = 1'b0;
    in_port = 4'hF;
    #1;
    check("mid_rst_readdata", rd_a, 32'd0);
    check("mid_rst_irq", {31'd0, irq_a}, 32'd0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    rd(0, 2'd0, 32'h0000_000F, "mid_rst_data");
    rd(1, 2'd3, 32'h0, "mid_rst_cap_any");
    rd(1, 2'd1, 32'h0, "mid_rst_mask");
    idle(10);
    rd(1, 2'd3, 32'h0, "mid_rst_no_late_edge");
    rd(1, 2'd0, 32'h0000_000F, "mid_rst_data_settled");

    idle(3);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
